// File: rtl/div_if.sv
// Handshake and operand/result bundle between the execute stage and div_unit.
interface div_if #(
    parameter int unsigned XLEN = 32
);
    logic            enable;
    logic            clear;
    logic            op_div;
    logic            op_divu;
    logic            op_rem;
    logic            op_remu;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] result;
    logic            ready;
    logic            busy;

    modport master (
        output enable, clear, op_div, op_divu, op_rem, op_remu, rdata1, rdata2,
        input  result, ready, busy
    );

    modport slave (
        input  enable, clear, op_div, op_divu, op_rem, op_remu, rdata1, rdata2,
        output result, ready, busy
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider: DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Divide-by-zero and signed overflow are resolved at start without iterating.
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic  clock,
    input logic  reset,
    div_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [XLEN-1:0] dvd, dvd_nxt;
    logic [XLEN-1:0] dvs, dvs_nxt;
    logic [XLEN-1:0] rem, rem_nxt;
    logic [XLEN-1:0] result_q, result_nxt;
    logic            neg_q, neg_q_nxt;
    logic            neg_r, neg_r_nxt;
    logic            is_rem, is_rem_nxt;
    logic            ready_q, ready_nxt;
    logic            busy_q, busy_nxt;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    // Start decode and special-case detection on the live operands
    logic            op_ok_c, signed_op_c, rem_op_c, a_neg_c, b_neg_c;
    logic            div_zero_c, ovf_c;
    logic [XLEN-1:0] abs_a_c, abs_b_c;

    assign op_ok_c     = $onehot({bus.op_div, bus.op_divu, bus.op_rem, bus.op_remu});
    assign signed_op_c = bus.op_div | bus.op_rem;
    assign rem_op_c    = bus.op_rem | bus.op_remu;
    assign a_neg_c     = signed_op_c & bus.rdata1[XLEN-1];
    assign b_neg_c     = signed_op_c & bus.rdata2[XLEN-1];
    assign abs_a_c     = a_neg_c ? negate(bus.rdata1) : bus.rdata1;
    assign abs_b_c     = b_neg_c ? negate(bus.rdata2) : bus.rdata2;
    assign div_zero_c  = (bus.rdata2 == '0);
    assign ovf_c       = signed_op_c && (bus.rdata1 == {1'b1, {(XLEN-1){1'b0}}})
                         && (bus.rdata2 == '1);

    // One restoring step; the extra top bit keeps large unsigned remainders exact
    logic [XLEN:0]   rem_sh_c, diff_c;
    logic            q_bit_c;
    logic [XLEN-1:0] rem_step_c, dvd_step_c;

    assign rem_sh_c   = {rem, dvd[XLEN-1]};
    assign diff_c     = rem_sh_c - {1'b0, dvs};
    assign q_bit_c    = ~diff_c[XLEN];
    assign rem_step_c = q_bit_c ? diff_c[XLEN-1:0] : rem_sh_c[XLEN-1:0];
    assign dvd_step_c = {dvd[XLEN-2:0], q_bit_c};

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dvd_nxt    = dvd;
        dvs_nxt    = dvs;
        rem_nxt    = rem;
        result_nxt = result_q;
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
        is_rem_nxt = is_rem;
        ready_nxt  = 1'b0;
        busy_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.enable && op_ok_c) begin
                    is_rem_nxt = rem_op_c;
                    if (div_zero_c) begin
                        result_nxt = rem_op_c ? bus.rdata1 : '1;
                        state_nxt  = DONE;
                        ready_nxt  = 1'b1;
                    end else if (ovf_c) begin
                        result_nxt = rem_op_c ? '0 : bus.rdata1;
                        state_nxt  = DONE;
                        ready_nxt  = 1'b1;
                    end else begin
                        dvd_nxt   = abs_a_c;
                        dvs_nxt   = abs_b_c;
                        rem_nxt   = '0;
                        cnt_nxt   = CW'(XLEN - 1);
                        neg_q_nxt = a_neg_c ^ b_neg_c;
                        neg_r_nxt = a_neg_c;
                        state_nxt = BUSY;
                        busy_nxt  = 1'b1;
                    end
                end
            end
            BUSY: begin
                rem_nxt  = rem_step_c;
                dvd_nxt  = dvd_step_c;
                cnt_nxt  = cnt - CW'(1);
                busy_nxt = 1'b1;
                if (cnt == '0) begin
                    state_nxt = DONE;
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    if (is_rem) result_nxt = neg_r ? negate(rem_step_c) : rem_step_c;
                    else        result_nxt = neg_q ? negate(dvd_step_c) : dvd_step_c;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Flush wins over any start or completion this cycle
        if (bus.clear) begin
            state_nxt  = IDLE;
            ready_nxt  = 1'b0;
            busy_nxt   = 1'b0;
            result_nxt = result_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_rem   <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dvd      <= dvd_nxt;
            dvs      <= dvs_nxt;
            rem      <= rem_nxt;
            result_q <= result_nxt;
            neg_q    <= neg_q_nxt;
            neg_r    <= neg_r_nxt;
            is_rem   <= is_rem_nxt;
            ready_q  <= ready_nxt;
            busy_q   <= busy_nxt;
        end
    end

    assign bus.result = result_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_div_unit;
    localparam int unsigned XLEN = 32;
    localparam int OP_DIV = 0, OP_DIVU = 1, OP_REM = 2, OP_REMU = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    div_if #(.XLEN(XLEN)) bus ();

    div_unit #(.XLEN(XLEN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_special(input int op, input logic [31:0] a, input logic [31:0] b);
        bit sgn = (op == OP_DIV) || (op == OP_REM);
        return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RV32M semantics straight from the ISA rules
    function automatic logic [31:0] ref_div(input int op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return (op == OP_REM || op == OP_REMU) ? a : 32'hFFFF_FFFF;
        if (is_special(op, a, b)) return (op == OP_REM) ? 32'd0 : a;
        case (op)
            OP_DIV:  return 32'(sa / sb);
            OP_DIVU: return a / b;
            OP_REM:  return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic drive_ops(input int op);
        bus.op_div  = (op == OP_DIV);
        bus.op_divu = (op == OP_DIVU);
        bus.op_rem  = (op == OP_REM);
        bus.op_remu = (op == OP_REMU);
    endtask

    // Issue one op in cycle 0; optionally re-assert enable (divu 1/1) at cycle inject_at
    task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b, input int inject_at,
                         output logic [31:0] res, output int lat, output logic busy1);
        @(negedge clock);
        bus.enable = 1'b1;
        drive_ops(op);
        bus.rdata1 = a;
        bus.rdata2 = b;
        @(negedge clock);
        bus.enable = 1'b0;
        drive_ops(-1);
        bus.rdata1 = $urandom;
        bus.rdata2 = $urandom;
        lat   = 1;
        busy1 = bus.busy;
        while (!bus.ready && lat < 200) begin
            if (lat == inject_at) begin
                bus.enable = 1'b1;
                drive_ops(OP_DIVU);
                bus.rdata1 = 32'd1;
                bus.rdata2 = 32'd1;
            end else begin
                bus.enable = 1'b0;
                drive_ops(-1);
            end
            @(negedge clock);
            lat++;
        end
        bus.enable = 1'b0;
        drive_ops(-1);
        res = bus.result;
    endtask

    task automatic run_op(input string tag, input int op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at);
        logic [31:0] res;
        int          lat;
        logic        busy1;
        bit          sp;
        sp = is_special(op, a, b);
        do_op(op, a, b, inject_at, res, lat, busy1);
        check({tag, ".result"}, res, ref_div(op, a, b));
        check({tag, ".latency"}, 32'(lat), sp ? 32'd1 : 32'(XLEN + 1));
        check({tag, ".busy_c1"}, {31'd0, busy1}, {31'd0, !sp});
        check({tag, ".busy_done"}, {31'd0, bus.busy}, 32'd0);
        @(negedge clock);
        check({tag, ".ready_pulse"}, {31'd0, bus.ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b, prev;
        int          op, sel;
        bit          seen;

        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        drive_ops(-1);
        bus.rdata1 = '0;
        bus.rdata2 = '0;
        #1;
        check("rst.result", bus.result, 32'd0);
        check("rst.ready", {31'd0, bus.ready}, 32'd0);
        check("rst.busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 0);
        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 0);
        run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 0);

        // Flush mid-operation
        prev = bus.result;
        @(negedge clock);
        bus.enable = 1'b1;
        drive_ops(OP_DIVU);
        bus.rdata1 = 32'd1000;
        bus.rdata2 = 32'd3;
        @(negedge clock);
        bus.enable = 1'b0;
        drive_ops(-1);
        repeat (9) @(negedge clock);
        bus.clear = 1'b1;
        @(negedge clock);
        bus.clear = 1'b0;
        check("clear.busy", {31'd0, bus.busy}, 32'd0);
        seen = bus.ready;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            seen |= bus.ready | bus.busy;
        end
        check("clear.no_ready", {31'd0, seen}, 32'd0);
        check("clear.result_held", bus.result, prev);
        run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 0);

        // Clear beats enable in the same cycle
        @(negedge clock);
        bus.enable = 1'b1;
        bus.clear  = 1'b1;
        drive_ops(OP_DIVU);
        bus.rdata1 = 32'd50;
        bus.rdata2 = 32'd0;
        @(negedge clock);
        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        drive_ops(-1);
        check("clear_vs_en.ready", {31'd0, bus.ready | bus.busy}, 32'd0);

        // Async reset mid-BUSY
        @(negedge clock);
        bus.enable = 1'b1;
        drive_ops(OP_DIVU);
        bus.rdata1 = 32'd77;
        bus.rdata2 = 32'd5;
        @(negedge clock);
        bus.enable = 1'b0;
        drive_ops(-1);
        repeat (5) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("amid.result", bus.result, 32'd0);
        check("amid.busy", {31'd0, bus.busy}, 32'd0);
        check("amid.ready", {31'd0, bus.ready}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_op("en_in_busy", OP_DIVU, 32'd100, 32'd7, 5);

        // Two op bits high: no start
        @(negedge clock);
        bus.enable = 1'b1;
        bus.op_div = 1'b1;
        bus.op_rem = 1'b1;
        bus.rdata1 = 32'd10;
        bus.rdata2 = 32'd0;
        @(negedge clock);
        bus.enable = 1'b0;
        drive_ops(-1);
        seen = 1'b0;
        for (int i = 0; i < 36; i++) begin
            seen |= bus.ready | bus.busy;
            @(negedge clock);
        end
        check("multi_op.no_start", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op  = int'($urandom_range(0, 3));
            sel = int'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            case (sel)
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = b >> $urandom_range(0, 31);
                4: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), op, a, b, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
